cnn_layer_sequencer: RTL and testbench

- Parametrised successor to the fixed three-layer CNN top-level controller.
- Sequences up to N_LAYERS compute layers (conv/pool/fc engines) with start-pulse/done handshakes.
- Adds a per-run layer bypass mask, batch repetition, a per-layer watchdog, abort, and error reporting.
- Sits between the core host interface and the layer engines; captures the final layer's result.

---
 rtl/cnn_layer_sequencer_if.sv | 37 +++
 rtl/cnn_layer_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_sequencer_if.sv
// Host and layer-engine signal bundle for cnn_layer_sequencer.
// The sequencer takes the slave side; the host/engine side takes master.
interface cnn_layer_sequencer_if #(
    parameter int N_LAYERS  = 3,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 8
) ();
    localparam int LIDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    logic                 enable;
    logic [CNT_W-1:0]     batch_len;
    logic [N_LAYERS-1:0]  layer_mask;
    logic [TIMEOUT_W-1:0] timeout_lim;
    logic                 abort;
    logic [N_LAYERS-1:0]  layer_start;
    logic [N_LAYERS-1:0]  layer_done;
    logic [DATA_W-1:0]    result_in;
    logic [DATA_W-1:0]    value;
    logic                 done;
    logic                 batch_done;
    logic                 busy;
    logic                 error;
    logic [1:0]           err_code;
    logic [LIDX_W-1:0]    err_layer;
    logic [CNT_W-1:0]     img_count;

    modport master (
        output enable, batch_len, layer_mask, timeout_lim, abort, layer_done, result_in,
        input  layer_start, value, done, batch_done, busy, error, err_code, err_layer, img_count
    );

    modport slave (
        input  enable, batch_len, layer_mask, timeout_lim, abort, layer_done, result_in,
        output layer_start, value, done, batch_done, busy, error, err_code, err_layer, img_count
    );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Sequences up to N_LAYERS compute engines per image with bypass mask, batch
// repetition, per-layer watchdog, abort and sticky error reporting.
module cnn_layer_sequencer #(
    parameter int N_LAYERS  = 3,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cnn_layer_sequencer_if.slave bus
);
    localparam int LIDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1'b1);
    localparam logic [TIMEOUT_W-1:0] TMR_ONE   = TIMEOUT_W'(1'b1);
    localparam logic [N_LAYERS-1:0]  START_ONE = N_LAYERS'(1'b1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;
    localparam logic [1:0] ERR_EMPTY   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT     = 3'd2,
        S_IMG_DONE = 3'd3,
        S_ERR      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [LIDX_W-1:0]    idx_q, idx_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [TIMEOUT_W-1:0] lim_q, lim_d;
    logic [N_LAYERS-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     img_q, img_d;
    logic [DATA_W-1:0]    value_q, value_d;
    logic                 done_q, done_d;
    logic                 bdone_q, bdone_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;
    logic [1:0]           code_q, code_d;
    logic [LIDX_W-1:0]    elyr_q, elyr_d;

    logic                 accept_s;
    logic                 img_s;
    logic [1:0]           err_ev_s;
    logic [CNT_W-1:0]     img_inc_s;

    function automatic logic [LIDX_W-1:0] lowest_set(input logic [N_LAYERS-1:0] m);
        logic [LIDX_W-1:0] r;
        r = {LIDX_W{1'b0}};
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            r = m[i] ? LIDX_W'(i) : r;
        end
        return r;
    endfunction

    function automatic logic [LIDX_W-1:0] next_above(input logic [N_LAYERS-1:0] m,
                                                     input logic [LIDX_W-1:0]   cur);
        logic [LIDX_W-1:0] r;
        r = {LIDX_W{1'b0}};
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            r = (m[i] && (LIDX_W'(i) > cur)) ? LIDX_W'(i) : r;
        end
        return r;
    endfunction

    function automatic logic any_above(input logic [N_LAYERS-1:0] m,
                                       input logic [LIDX_W-1:0]   cur);
        logic found;
        found = 1'b0;
        for (int i = 0; i < N_LAYERS; i++) begin
            found = found | (m[i] & (LIDX_W'(i) > cur));
        end
        return found;
    endfunction

    assign img_inc_s = img_q + CNT_ONE;

    // State, run context and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= {LIDX_W{1'b0}};
            timer_q <= {TIMEOUT_W{1'b0}};
            lim_q   <= {TIMEOUT_W{1'b0}};
            mask_q  <= {N_LAYERS{1'b0}};
            len_q   <= {CNT_W{1'b0}};
            img_q   <= {CNT_W{1'b0}};
            value_q <= {DATA_W{1'b0}};
            done_q  <= 1'b0;
            bdone_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= 2'b00;
            elyr_q  <= {LIDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            lim_q   <= lim_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            img_q   <= img_d;
            value_q <= value_d;
            done_q  <= done_d;
            bdone_q <= bdone_d;
            busy_q  <= busy_d;
            error_q <= error_d;
            code_q  <= code_d;
            elyr_q  <= elyr_d;
        end
    end

    // Next-state logic; also flags accept / image-complete / error events.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        lim_d    = lim_q;
        mask_d   = mask_q;
        len_d    = len_q;
        accept_s = 1'b0;
        img_s    = 1'b0;
        err_ev_s = ERR_NONE;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    accept_s = 1'b1;
                    mask_d   = bus.layer_mask;
                    lim_d    = bus.timeout_lim;
                    len_d    = (bus.batch_len == {CNT_W{1'b0}}) ? CNT_ONE : bus.batch_len;
                    idx_d    = lowest_set(bus.layer_mask);
                    if (|bus.layer_mask) begin
                        state_d = S_START;
                    end else begin
                        state_d  = S_ERR;
                        err_ev_s = ERR_EMPTY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                timer_d = {TIMEOUT_W{1'b0}};
                if (bus.abort) begin
                    state_d  = S_ERR;
                    err_ev_s = ERR_ABORT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TMR_ONE;
                if (bus.abort) begin
                    state_d  = S_ERR;
                    err_ev_s = ERR_ABORT;
                end else if (bus.layer_done[idx_q]) begin
                    if (any_above(mask_q, idx_q)) begin
                        idx_d   = next_above(mask_q, idx_q);
                        state_d = S_START;
                    end else begin
                        img_s   = 1'b1;
                        state_d = S_IMG_DONE;
                    end
                end else if ((lim_q != {TIMEOUT_W{1'b0}}) && (timer_q == lim_q - TMR_ONE)) begin
                    state_d  = S_ERR;
                    err_ev_s = ERR_TIMEOUT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_IMG_DONE: begin
                if (bus.abort) begin
                    state_d  = S_ERR;
                    err_ev_s = ERR_ABORT;
                end else if (img_q == len_q) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = lowest_set(mask_q);
                    state_d = S_START;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output registers are loaded on entry to the state that shows them.
    always_comb begin
        value_d = value_q;
        done_d  = 1'b0;
        bdone_d = 1'b0;
        busy_d  = (state_d != S_IDLE);
        error_d = error_q;
        code_d  = code_q;
        elyr_d  = elyr_q;
        img_d   = img_q;
        if (accept_s) begin
            error_d = 1'b0;
            code_d  = ERR_NONE;
            elyr_d  = {LIDX_W{1'b0}};
            img_d   = {CNT_W{1'b0}};
        end else begin
            img_d = img_q;
        end
        if (err_ev_s != ERR_NONE) begin
            error_d = 1'b1;
            code_d  = err_ev_s;
            elyr_d  = (err_ev_s == ERR_EMPTY) ? {LIDX_W{1'b0}} : idx_q;
        end else begin
            code_d = code_d;
        end
        if (img_s) begin
            value_d = bus.result_in;
            done_d  = 1'b1;
            img_d   = img_inc_s;
            bdone_d = (img_inc_s == len_q);
        end else begin
            value_d = value_q;
        end
    end

    assign bus.layer_start = (state_q == S_START) ? (START_ONE << idx_q) : {N_LAYERS{1'b0}};
    assign bus.value       = value_q;
    assign bus.done        = done_q;
    assign bus.batch_done  = bdone_q;
    assign bus.busy        = busy_q;
    assign bus.error       = error_q;
    assign bus.err_code    = code_q;
    assign bus.err_layer   = elyr_q;
    assign bus.img_count   = img_q;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: a small engine model answers start
// pulses, expected results are queued as final-layer dones are driven.
module tb_cnn_layer_sequencer;
    localparam int NL = 3;
    localparam int DW = 32;
    localparam int TW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cnn_layer_sequencer_if #(.N_LAYERS(NL), .DATA_W(DW), .TIMEOUT_W(TW), .CNT_W(CW)) bus ();

    cnn_layer_sequencer #(.N_LAYERS(NL), .DATA_W(DW), .TIMEOUT_W(TW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [DW-1:0] val;
        logic [CW-1:0] cnt;
        logic          bd;
    } exp_t;

    exp_t sb_q[$];
    int   start_cyc_q[$];
    int   start_idx_q[$];
    int   done_cyc_q[$];
    int   err_cyc;
    int   busy_low_cyc;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_outs"}, {bus.layer_start, bus.done, bus.batch_done, bus.busy, bus.error,
                                   bus.err_code, bus.err_layer, bus.img_count}, 64'd0);
        check_val({tag, "_value"}, bus.value, 64'd0);
    endtask

    // Runs one enable request for ncyc cycles; cycle 0 is the enable cycle.
    task automatic run(input logic [NL-1:0] mask, input logic [CW-1:0] len, input logic [TW-1:0] lim,
                       input int dly[3], input int abort_at, input int rst_at, input int spur_at,
                       input logic [DW-1:0] base, input int ncyc);
        int       pend[3];
        int       hi;
        int       img;
        int       eff_len;
        exp_t     e;
        start_cyc_q.delete();
        start_idx_q.delete();
        done_cyc_q.delete();
        sb_q.delete();
        err_cyc      = -1;
        busy_low_cyc = -1;
        pend         = '{-1, -1, -1};
        img          = 0;
        eff_len      = (len == 8'd0) ? 1 : int'(len);
        hi           = -1;
        for (int i = 0; i < NL; i++) if (mask[i]) hi = i;
        for (int r = 0; r < ncyc; r++) begin
            bus.enable      = (r == 0);
            bus.layer_mask  = mask;
            bus.batch_len   = len;
            bus.timeout_lim = lim;
            bus.abort       = (r == abort_at);
            bus.result_in   = base + DW'(r);
            bus.layer_done  = 3'b000;
            for (int i = 0; i < NL; i++) if (pend[i] == r) bus.layer_done[i] = 1'b1;
            if (r == spur_at) bus.layer_done[1] = 1'b1;
            if (hi >= 0 && pend[hi] == r && r != abort_at) begin
                img++;
                sb_q.push_back('{val: base + DW'(r), cnt: CW'(img), bd: (img == eff_len)});
            end
            if (r == abort_at) pend = '{-1, -1, -1};
            if (r == rst_at + 1) rst = 1'b1;
            if (r == rst_at) begin
                #2 rst = 1'b0;
                pend = '{-1, -1, -1};
            end
            @(negedge clk);
            if (r == rst_at) check_idle_outputs("async_reset");
            for (int i = 0; i < NL; i++) begin
                if (bus.layer_start[i]) begin
                    start_cyc_q.push_back(r);
                    start_idx_q.push_back(i);
                    if (dly[i] > 0) pend[i] = r + dly[i];
                end
            end
            if (bus.done) begin
                done_cyc_q.push_back(r);
                check_val("sb_depth", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_val("value", bus.value, e.val);
                    check_val("img_count", bus.img_count, e.cnt);
                    check_val("batch_done", bus.batch_done, e.bd);
                end
            end
            if (bus.batch_done) check_val("bd_with_done", bus.done, 64'd1);
            if (r >= 1 && bus.error && err_cyc < 0) err_cyc = r;
            if (r >= 1 && !bus.busy && busy_low_cyc < 0) busy_low_cyc = r;
            @(posedge clk);
            #1;
        end
        check_val("sb_left", sb_q.size(), 64'd0);
    endtask

    task automatic expect_starts(input string tag, input int n, input int ec[3], input int ei[3]);
        check_val({tag, "_nstart"}, start_cyc_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < start_cyc_q.size()) begin
                check_val({tag, "_start_cyc"}, start_cyc_q[k], ec[k]);
                check_val({tag, "_start_idx"}, start_idx_q[k], ei[k]);
            end
        end
    endtask

    task automatic expect_dones(input string tag, input int n, input int ec[3]);
        check_val({tag, "_ndone"}, done_cyc_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < done_cyc_q.size()) check_val({tag, "_done_cyc"}, done_cyc_q[k], ec[k]);
        end
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.layer_mask  = 3'b000;
        bus.batch_len   = 8'd0;
        bus.timeout_lim = 16'd0;
        bus.abort       = 1'b0;
        bus.layer_done  = 3'b000;
        bus.result_in   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        run(3'b111, 8'd1, 16'd0, '{2, 2, 2}, -1, -1, -1, 32'hFFFF_FFED, 14);
        expect_starts("normal", 3, '{1, 4, 7}, '{0, 1, 2});
        expect_dones("normal", 1, '{10, 0, 0});
        check_val("normal_busy_low", busy_low_cyc, 64'd11);
        check_val("normal_value", bus.value, 64'hFFFF_FFF6);
        check_val("normal_no_err", err_cyc, -64'sd1);

        run(3'b101, 8'd1, 16'd0, '{1, 1, 1}, -1, -1, 2, 32'h1234_0000, 8);
        expect_starts("bypass", 2, '{1, 3, 0}, '{0, 2, 0});
        expect_dones("bypass", 1, '{5, 0, 0});

        run(3'b111, 8'd3, 16'd0, '{1, 1, 1}, -1, -1, -1, 32'h0BAD_0000, 24);
        expect_dones("batch", 3, '{7, 14, 21});
        check_val("batch_busy_low", busy_low_cyc, 64'd22);

        run(3'b111, 8'd1, 16'd5, '{2, 0, 2}, -1, -1, -1, 32'h5555_0000, 14);
        expect_dones("wdog", 0, '{0, 0, 0});
        if (start_cyc_q.size() >= 2) check_val("wdog_latency", err_cyc - start_cyc_q[1], 64'd6);
        else check_val("wdog_nstart", start_cyc_q.size(), 64'd2);
        check_val("wdog_code", bus.err_code, 64'd1);
        check_val("wdog_layer", bus.err_layer, 64'd1);

        run(3'b111, 8'd1, 16'd5, '{2, 5, 2}, -1, -1, -1, 32'h6666_0000, 17);
        check_val("wdog_edge_no_err", err_cyc, -64'sd1);
        expect_dones("wdog_edge", 1, '{13, 0, 0});

        run(3'b111, 8'd1, 16'd0, '{1, 1, 4}, 7, -1, -1, 32'h7777_0000, 10);
        expect_dones("abort", 0, '{0, 0, 0});
        check_val("abort_err_cyc", err_cyc, 64'd8);
        check_val("abort_code", bus.err_code, 64'd2);
        check_val("abort_layer", bus.err_layer, 64'd2);

        run(3'b111, 8'd1, 16'd0, '{1, 1, 2}, 7, -1, -1, 32'h8888_0000, 10);
        expect_dones("abort_on_done", 0, '{0, 0, 0});
        check_val("abort_on_done_code", bus.err_code, 64'd2);

        run(3'b000, 8'd1, 16'd0, '{1, 1, 1}, -1, -1, -1, 32'h9999_0000, 4);
        expect_starts("empty", 0, '{0, 0, 0}, '{0, 0, 0});
        check_val("empty_err_cyc", err_cyc, 64'd1);
        check_val("empty_code", bus.err_code, 64'd3);
        check_val("empty_layer", bus.err_layer, 64'd0);
        check_val("empty_busy_low", busy_low_cyc, 64'd2);

        run(3'b001, 8'd0, 16'd0, '{1, 1, 1}, -1, -1, -1, 32'hAAAA_0000, 6);
        expect_dones("len0", 1, '{3, 0, 0});
        check_val("len0_err_cleared", err_cyc, -64'sd1);

        run(3'b111, 8'd1, 16'd0, '{2, 2, 2}, -1, 5, -1, 32'hBBBB_0000, 10);
        expect_dones("reset_run", 0, '{0, 0, 0});

        run(3'b111, 8'd1, 16'd0, '{2, 2, 2}, -1, -1, -1, 32'hCCCC_0000, 14);
        expect_starts("post_reset", 3, '{1, 4, 7}, '{0, 1, 2});
        expect_dones("post_reset", 1, '{10, 0, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
